// File: rtl/boot_ctrl.sv
// Boot sequencer: synchronises PLL lock and the reset button, debounces the button,
// and sequences MCU reset release and the start pulse, with loader override.
module boot_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES    = 16,
  parameter int unsigned HOLD_CYCLES        = 4,
  parameter logic [31:0] DEFAULT_START_ADDR = 32'h8000_0000,
  parameter logic [31:0] DEFAULT_STACK_ADDR = 32'h8000_3FF0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        crest_n,
  input  logic        loader_cpu_reset,
  input  logic        loader_cpu_start,
  input  logic [31:0] loader_start_addr,
  output logic        cpu_reset_n,
  output logic        cpu_start,
  output logic [31:0] cpu_start_addr,
  output logic        stack_we,
  output logic [31:0] stack_data,
  output logic [1:0]  boot_state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_e;

  logic              pll_meta_q, pll_meta_d, pll_sync_q, pll_sync_d;
  logic              btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic              btn_db_q, btn_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]       pend_addr_q, pend_addr_d;
  state_e            state_q, state_d;
  logic              cpu_reset_n_q, cpu_reset_n_d;
  logic              cpu_start_q, cpu_start_d;
  logic              stack_we_q, stack_we_d;
  logic [31:0]       start_addr_q, start_addr_d;
  logic              abort;

  // Synchronisers and debouncer; btn_db_q = 1 means released.
  always_comb begin
    pll_meta_d = pll_locked;
    pll_sync_d = pll_meta_q;
    btn_meta_d = crest_n;
    btn_sync_d = btn_meta_q;
    btn_db_d   = btn_db_q;
    db_cnt_d   = db_cnt_q;
    if (btn_sync_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q >= DB_LAST) begin
      btn_db_d = btn_sync_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign abort = ~pll_sync_q | ~btn_db_q;

  // Priority: abort > loader start > loader reset > hold count.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pend_addr_d = pend_addr_q;
    unique case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (loader_cpu_start) begin
          state_d     = START;
          pend_addr_d = loader_start_addr;
        end else if (!loader_cpu_reset) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (loader_cpu_start) begin
          state_d     = START;
          pend_addr_d = loader_start_addr;
        end else if (loader_cpu_reset) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = START;
          pend_addr_d = DEFAULT_START_ADDR;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (loader_cpu_start) begin
          state_d     = START;
          pend_addr_d = loader_start_addr;
        end else if (loader_cpu_reset) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside boot_state.
  always_comb begin
    cpu_reset_n_d = (state_d == START) || (state_d == RUN);
    cpu_start_d   = (state_d == START);
    stack_we_d    = (state_d == START);
    start_addr_d  = (state_d == START) ? pend_addr_d : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_meta_q    <= 1'b0;
      pll_sync_q    <= 1'b0;
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      btn_db_q      <= 1'b1;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      pend_addr_q   <= 32'h0;
      state_q       <= IDLE;
      cpu_reset_n_q <= 1'b0;
      cpu_start_q   <= 1'b0;
      stack_we_q    <= 1'b0;
      start_addr_q  <= 32'h0;
    end else begin
      pll_meta_q    <= pll_meta_d;
      pll_sync_q    <= pll_sync_d;
      btn_meta_q    <= btn_meta_d;
      btn_sync_q    <= btn_sync_d;
      btn_db_q      <= btn_db_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      pend_addr_q   <= pend_addr_d;
      state_q       <= state_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      cpu_start_q   <= cpu_start_d;
      stack_we_q    <= stack_we_d;
      start_addr_q  <= start_addr_d;
    end
  end

  assign cpu_reset_n    = cpu_reset_n_q;
  assign cpu_start      = cpu_start_q;
  assign stack_we       = stack_we_q;
  assign cpu_start_addr = start_addr_q;
  assign stack_data     = DEFAULT_STACK_ADDR;
  assign boot_state     = state_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: a cycle table for power-on and loader flows,
// plus hand sequences for PLL loss, button debounce and reset during START.
module tb_boot_ctrl;

  localparam logic [31:0] DEF_START = 32'h8000_0000;
  localparam logic [31:0] DEF_STACK = 32'h8000_3FF0;
  localparam logic [1:0] S_IDLE = 2'd0, S_HOLD = 2'd1, S_START = 2'd2, S_RUN = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pll_locked = 1'b1;
  logic        crest_n = 1'b1;
  logic        loader_cpu_reset = 1'b0;
  logic        loader_cpu_start = 1'b0;
  logic [31:0] loader_start_addr = 32'h0;
  logic        cpu_reset_n, cpu_start, stack_we;
  logic [31:0] cpu_start_addr, stack_data;
  logic [1:0]  boot_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        ldr;
    logic        lds;
    logic [31:0] addr;
    logic [1:0]  exp_state;
    logic        exp_rst_n;
    logic        exp_start;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[$];

  boot_ctrl dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .crest_n(crest_n),
    .loader_cpu_reset(loader_cpu_reset), .loader_cpu_start(loader_cpu_start),
    .loader_start_addr(loader_start_addr), .cpu_reset_n(cpu_reset_n),
    .cpu_start(cpu_start), .cpu_start_addr(cpu_start_addr), .stack_we(stack_we),
    .stack_data(stack_data), .boot_state(boot_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ldr, input logic lds, input logic [31:0] addr,
                     input logic [1:0] st, input logic rn, input logic sp,
                     input logic [31:0] ea);
    vec_t v;
    v.ldr = ldr; v.lds = lds; v.addr = addr;
    v.exp_state = st; v.exp_rst_n = rn; v.exp_start = sp; v.exp_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (boot_state !== s && n < budget) begin
      step();
      n++;
    end
    check(name, {30'h0, boot_state}, {30'h0, s});
  endtask

  // Scoreboard for start pulses: every pulse must match the next expected address.
  always @(negedge clk) begin
    if (reset_n) begin
      check("stack_we_eq_start", {31'h0, stack_we}, {31'h0, cpu_start});
      if (cpu_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start_pulse", {31'h0, cpu_start}, 32'h0);
        end else begin
          check("start_addr", cpu_start_addr, exp_q.pop_front());
          check("start_state", {30'h0, boot_state}, {30'h0, S_START});
        end
      end
    end
  end

  initial begin
    int hold_len;
    logic left_run;

    // Cycle table: released from reset with PLL locked and button up.
    add(0, 0, 32'h0,         S_IDLE,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_IDLE,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_START, 1, 1, DEF_START);
    add(0, 0, 32'h0,         S_RUN,   1, 0, 32'h0);
    add(0, 0, 32'h0,         S_RUN,   1, 0, 32'h0);
    add(1, 0, 32'h0,         S_IDLE,  0, 0, 32'h0);
    add(1, 0, 32'h0,         S_IDLE,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 1, 32'h8000_1000, S_START, 1, 1, 32'h8000_1000);
    add(0, 0, 32'h5555_5555, S_RUN,   1, 0, 32'h0);
    add(1, 1, 32'h1234_5678, S_START, 1, 1, 32'h1234_5678);
    add(0, 1, 32'hAAAA_AAAA, S_RUN,   1, 0, 32'h0);
    add(0, 0, 32'h0,         S_RUN,   1, 0, 32'h0);
    add(1, 0, 32'h0,         S_IDLE,  0, 0, 32'h0);
    add(1, 0, 32'h0,         S_IDLE,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(1, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(1, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_HOLD,  0, 0, 32'h0);
    add(0, 0, 32'h0,         S_START, 1, 1, DEF_START);
    add(0, 0, 32'h0,         S_RUN,   1, 0, 32'h0);

    // Reset values.
    repeat (3) step();
    check("rst_state", {30'h0, boot_state}, {30'h0, S_IDLE});
    check("rst_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
    check("rst_cpu_start", {31'h0, cpu_start}, 32'h0);
    check("rst_stack_we", {31'h0, stack_we}, 32'h0);
    check("rst_start_addr", cpu_start_addr, 32'h0);
    check("rst_stack_data", stack_data, DEF_STACK);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      loader_cpu_reset  = vecs[i].ldr;
      loader_cpu_start  = vecs[i].lds;
      loader_start_addr = vecs[i].addr;
      if (vecs[i].exp_start) exp_q.push_back(vecs[i].exp_addr);
      step();
      check($sformatf("vec%0d_state", i), {30'h0, boot_state}, {30'h0, vecs[i].exp_state});
      check($sformatf("vec%0d_rst_n", i), {31'h0, cpu_reset_n}, {31'h0, vecs[i].exp_rst_n});
      check($sformatf("vec%0d_start", i), {31'h0, cpu_start}, {31'h0, vecs[i].exp_start});
      check($sformatf("vec%0d_addr", i), cpu_start_addr, vecs[i].exp_addr);
    end
    loader_cpu_start = 1'b0;
    loader_cpu_reset = 1'b0;
    check("run_stack_data", stack_data, DEF_STACK);

    // PLL glitch of one cycle in RUN: IDLE within 3 cycles, then default reboot.
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_state(S_IDLE, 3, "pll_loss_idle");
    exp_q.push_back(DEF_START);
    wait_state(S_START, 20, "pll_reboot_start");
    wait_state(S_RUN, 2, "pll_reboot_run");

    // Start+reset pulse while PLL unlocked is ignored.
    pll_locked = 1'b0;
    wait_state(S_IDLE, 5, "unlock_idle");
    loader_cpu_start = 1'b1;
    loader_cpu_reset = 1'b1;
    loader_start_addr = 32'hDEAD_BEEF;
    step();
    loader_cpu_start = 1'b0;
    loader_cpu_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("unlock_stay_idle", {30'h0, boot_state}, {30'h0, S_IDLE});
      check("unlock_no_start", {31'h0, cpu_start}, 32'h0);
      step();
    end
    pll_locked = 1'b1;
    exp_q.push_back(DEF_START);
    wait_state(S_START, 20, "relock_start");
    wait_state(S_RUN, 2, "relock_run");

    // Button low for 15 cycles: filtered out.
    crest_n = 1'b0;
    repeat (15) step();
    crest_n = 1'b1;
    left_run = 1'b0;
    repeat (25) begin
      if (boot_state !== S_RUN) left_run = 1'b1;
      step();
    end
    check("bounce15_stays_run", {31'h0, left_run}, 32'h0);

    // Button low long enough: IDLE, then a full reboot after release.
    crest_n = 1'b0;
    wait_state(S_IDLE, 25, "press_idle");
    check("press_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
    repeat (4) step();
    check("press_still_idle", {30'h0, boot_state}, {30'h0, S_IDLE});
    crest_n = 1'b1;
    exp_q.push_back(DEF_START);
    wait_state(S_HOLD, 40, "release_hold");
    hold_len = 0;
    while (boot_state === S_HOLD && hold_len < 10) begin
      step();
      hold_len++;
    end
    check("hold_len", hold_len, 4);
    check("release_start", {30'h0, boot_state}, {30'h0, S_START});
    step();
    check("release_run", {30'h0, boot_state}, {30'h0, S_RUN});

    // Reset asserted during START clears outputs at once; no pulse afterwards.
    loader_cpu_start = 1'b1;
    loader_start_addr = 32'h8000_2000;
    step();
    loader_cpu_start = 1'b0;
    check("pre_reset_start", {30'h0, boot_state}, {30'h0, S_START});
    reset_n = 1'b0;
    #1;
    check("async_state", {30'h0, boot_state}, {30'h0, S_IDLE});
    check("async_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
    check("async_cpu_start", {31'h0, cpu_start}, 32'h0);
    check("async_stack_we", {31'h0, stack_we}, 32'h0);
    check("async_start_addr", cpu_start_addr, 32'h0);
    check("async_stack_data", stack_data, DEF_STACK);
    @(posedge clk);
    #1;
    check("reset_edge_no_start", {31'h0, cpu_start}, 32'h0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_reset_no_start", {31'h0, cpu_start}, 32'h0);
    end
    exp_q.push_back(DEF_START);
    wait_state(S_START, 20, "post_reset_boot");
    wait_state(S_RUN, 2, "post_reset_run");

    step();
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the count of consecutive stable samples needed to accept a change on the button.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, the number of cycles cpu_reset_n is held low before a boot start.
REQ-003 SHALL have parameter DEFAULT_START_ADDR, default 32'h8000_0000, the power-on boot address.
REQ-004 SHALL have parameter DEFAULT_STACK_ADDR, default 32'h8000_3FF0, the value written to x2 at each start.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: asynchronous PLL lock indication.
REQ-008 SHALL have port crest_n, input, 1 bit: asynchronous raw push-button, low = pressed.
REQ-009 SHALL have port loader_cpu_reset, input, 1 bit: level from the hardware loader requesting the CPU be held in reset.
REQ-010 SHALL have port loader_cpu_start, input, 1 bit: single-cycle pulse from the hardware loader requesting a start.
REQ-011 SHALL have port loader_start_addr, input, 32 bits: start address, valid with loader_cpu_start.
REQ-012 SHALL have port cpu_reset_n, output, 1 bit: low holds the MCU in reset.
REQ-013 SHALL have port cpu_start, output, 1 bit: single-cycle start pulse to the MCU.
REQ-014 SHALL have port cpu_start_addr, output, 32 bits: start address, valid while cpu_start = 1.
REQ-015 SHALL have port stack_we, output, 1 bit: register-file write enable for x2, asserted in the same cycle as cpu_start.
REQ-016 SHALL have port stack_data, output, 32 bits: held constant at DEFAULT_STACK_ADDR.
REQ-017 SHALL have port boot_state, output, 2 bits: current state encoding (IDLE=0, HOLD=1, START=2, RUN=3).

Function
REQ-018 SHALL pass pll_locked and crest_n each through a 2-flop synchroniser before any use; both synchroniser flops SHALL reset to 0.
REQ-019 SHALL change the debounced button state only after the synchronised crest_n differs from it for DEBOUNCE_CYCLES consecutive cycles; any sample equal to the current debounced state SHALL clear the counter.
REQ-020 SHALL saturate the debounce counter; its width SHALL be clog2(DEBOUNCE_CYCLES+1).
REQ-021 SHALL treat the condition "abort" as: synchronised pll_locked = 0, or debounced button pressed.
REQ-022 SHALL implement a 4-state FSM with states IDLE, HOLD, START and RUN.
REQ-023 IDLE: cpu_reset_n = 0; go to HOLD when abort = 0 and loader_cpu_reset = 0.
REQ-024 HOLD: cpu_reset_n = 0; count HOLD_CYCLES cycles, then go to START; go to IDLE on abort; restart the count while loader_cpu_reset = 1.
REQ-025 START: lasts exactly one cycle with cpu_reset_n = 1, cpu_start = 1 and stack_we = 1; always go to RUN next.
REQ-026 RUN: cpu_reset_n = 1; go to IDLE on abort or on loader_cpu_reset = 1.
REQ-027 A loader_cpu_start pulse seen in IDLE, HOLD or RUN with abort = 0 SHALL go directly to START and latch loader_start_addr as the pending address.
REQ-028 A START reached through the HOLD count SHALL use DEFAULT_START_ADDR; cpu_start_addr SHALL equal the pending address while cpu_start = 1 and SHALL be 0 otherwise.
REQ-029 Priority, highest first: abort, then loader_cpu_start, then loader_cpu_reset, then the HOLD count.
- If loader_cpu_start and loader_cpu_reset are both 1 in the same cycle, the start wins.
REQ-030 A loader_cpu_start arriving during START SHALL be ignored.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.
- cpu_start and stack_we SHALL be asserted in the same cycle that boot_state = START.

Reset
REQ-032 While reset_n = 0, the block SHALL hold:
- state = IDLE, cpu_reset_n = 0, cpu_start = 0, stack_we = 0, cpu_start_addr = 0;
- debounced button = released, all counters = 0.
REQ-033 reset_n asserted mid-operation, including during START, SHALL immediately force the REQ-032 values; no partial pulse SHALL follow reset release.
REQ-034 stack_data SHALL equal DEFAULT_STACK_ADDR both in reset and out of it.

Verification
REQ-035 Power-on: release reset_n with pll_locked = 1 and crest_n = 1 -> exactly one cpu_start pulse, with cpu_start_addr = 32'h8000_0000 and stack_we = 1, then boot_state = RUN.
REQ-036 Button bounce: crest_n low for 15 cycles -> no state change; crest_n low for 16 or more cycles -> IDLE with cpu_reset_n = 0; after release -> IDLE, HOLD (4 cycles), START, RUN.
REQ-037 Loader flow: loader_cpu_reset = 1 in RUN -> IDLE; drop it, then pulse loader_cpu_start with addr 32'h8000_1000 -> single cpu_start with cpu_start_addr = 32'h8000_1000.
REQ-038 Simultaneous: loader_cpu_start and loader_cpu_reset both high in RUN -> START using the loader address.
- Same pulse while pll_locked = 0 -> ignored; state stays IDLE.
REQ-039 PLL loss: pll_locked low for 1 cycle in RUN -> IDLE within 3 cycles, then an automatic reboot to DEFAULT_START_ADDR.
REQ-040 Reset during START: reset_n asserted -> outputs take the REQ-032 values asynchronously, and cpu_start is not seen high on the next clock edge.
